// File: rtl/proc_pkg.sv
// Shared constants for the multi-channel compare FIFO: selection modes and
// default geometry.
package proc_pkg;
    localparam int MODE_MAX     = 0;
    localparam int MODE_MIN     = 1;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 18;
endpackage

// File: rtl/proc_chan_fifo.sv
// Single-channel synchronous FIFO with occupancy count; depth need not be a
// power of two, so both pointers wrap explicitly at DEPTH-1.
module proc_chan_fifo
    import proc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  level,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    // Full is judged on the registered level, so a full FIFO refuses a write
    // even when a pop happens in the same cycle.
    assign full    = (level_q == CNT_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level_d = level_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end
endmodule

// File: rtl/multi_chan_compare_fifo.sv
// N-channel lock-step FIFO bank: pops one word from every channel together,
// keeps the greatest (or smallest) and presents it on a registered output.
module multi_chan_compare_fifo
    import proc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int MODE   = MODE_MAX,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [NUM_CH*CNT_W-1:0]  level,
    output logic [NUM_CH-1:0]        drop_flag,
    input  logic                     clear_drop,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);
    logic [DATA_W-1:0] head [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic              fire;

    logic [NUM_CH-1:0] drop_flag_q, drop_flag_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [DATA_W-1:0] best_data;
    logic [CH_W-1:0]   best_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        proc_chan_fifo #(
            .DATA_W(DATA_W),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .flush(flush),
            .push (in_valid[c]),
            .pop  (fire),
            .wdata(in_data[c*DATA_W +: DATA_W]),
            .rdata(head[c]),
            .level(level[c*CNT_W +: CNT_W]),
            .full (full[c]),
            .empty(empty[c])
        );
    end

    assign in_ready = ~full;
    assign fire     = (empty == '0) && (!out_valid_q || out_ready) && !flush;

    // Strict comparison keeps the earlier channel on ties.
    always_comb begin
        best_data = head[0];
        best_ch   = '0;
        for (int c = 1; c < NUM_CH; c++) begin
            if ((MODE == MODE_MIN) ? (head[c] < best_data) : (head[c] > best_data)) begin
                best_data = head[c];
                best_ch   = CH_W'(c);
            end
        end
    end

    always_comb begin
        drop_flag_d = (drop_flag_q & ~{NUM_CH{clear_drop}}) | (in_valid & full);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = best_data;
            out_ch_d    = best_ch;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_flag_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            drop_flag_q <= drop_flag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign drop_flag = drop_flag_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_multi_chan_compare_fifo.sv
// Scoreboard bench: a 2-channel max instance and two 4-channel instances
// (max and min) sharing stimulus; a monitor checks every output transfer.
module tb_multi_chan_compare_fifo;
    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        flush_a, clear_drop_a, out_ready_a;
    logic [1:0]  in_valid_a;
    logic [15:0] in_data_a;
    logic [1:0]  in_ready_a, drop_flag_a;
    logic [9:0]  level_a;
    logic        out_valid_a;
    logic [7:0]  out_data_a;
    logic [0:0]  out_ch_a;

    logic        flush_b, clear_drop_b, out_ready_b;
    logic [3:0]  in_valid_b;
    logic [31:0] in_data_b;
    logic [3:0]  in_ready_b, drop_flag_b, in_ready_c, drop_flag_c;
    logic [11:0] level_b, level_c;
    logic        out_valid_b, out_valid_c;
    logic [7:0]  out_data_b, out_data_c;
    logic [1:0]  out_ch_b, out_ch_c;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_a[$];
    exp_t exp_bx[$];
    exp_t exp_bn[$];
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    exp_t ea, eb, ec;

    multi_chan_compare_fifo #(.NUM_CH(2), .DATA_W(8), .DEPTH(18), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .in_valid(in_valid_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .level(level_a), .drop_flag(drop_flag_a),
        .clear_drop(clear_drop_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_ch(out_ch_a), .out_ready(out_ready_a)
    );

    multi_chan_compare_fifo #(.NUM_CH(4), .DATA_W(8), .DEPTH(4), .MODE(0)) dut_bx (
        .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .level(level_b), .drop_flag(drop_flag_b),
        .clear_drop(clear_drop_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_ch(out_ch_b), .out_ready(out_ready_b)
    );

    multi_chan_compare_fifo #(.NUM_CH(4), .DATA_W(8), .DEPTH(4), .MODE(1)) dut_bn (
        .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_c), .level(level_c), .drop_flag(drop_flag_c),
        .clear_drop(clear_drop_b), .out_valid(out_valid_c), .out_data(out_data_c),
        .out_ch(out_ch_c), .out_ready(out_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the end of the run");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: every accepted output must match the head of its expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            n_vec++;
            if (exp_a.size() == 0) begin
                n_err++;
                $display("[TB] FAIL a_extra got data=%h ch=%0d required no output", out_data_a, out_ch_a);
            end else begin
                ea = exp_a.pop_front();
                if (out_data_a !== ea.data || {1'b0, out_ch_a} !== ea.ch) begin
                    n_err++;
                    $display("[TB] FAIL a_result got data=%h ch=%0d required data=%h ch=%0d",
                             out_data_a, out_ch_a, ea.data, ea.ch);
                end
            end
        end
        if (!rst && out_valid_b && out_ready_b) begin
            n_vec++;
            if (exp_bx.size() == 0) begin
                n_err++;
                $display("[TB] FAIL bmax_extra got data=%h ch=%0d required no output", out_data_b, out_ch_b);
            end else begin
                eb = exp_bx.pop_front();
                if (out_data_b !== eb.data || out_ch_b !== eb.ch) begin
                    n_err++;
                    $display("[TB] FAIL bmax_result got data=%h ch=%0d required data=%h ch=%0d",
                             out_data_b, out_ch_b, eb.data, eb.ch);
                end
            end
        end
        if (!rst && out_valid_c && out_ready_b) begin
            n_vec++;
            if (exp_bn.size() == 0) begin
                n_err++;
                $display("[TB] FAIL bmin_extra got data=%h ch=%0d required no output", out_data_c, out_ch_c);
            end else begin
                ec = exp_bn.pop_front();
                if (out_data_c !== ec.data || out_ch_c !== ec.ch) begin
                    n_err++;
                    $display("[TB] FAIL bmin_result got data=%h ch=%0d required data=%h ch=%0d",
                             out_data_c, out_ch_c, ec.data, ec.ch);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s got %h required %h", name, act, req);
        end
    endtask

    // Reference for the 2-channel max instance: word queues per channel,
    // paired off in order whenever both hold data.
    task automatic modelA(input logic [1:0] v, input logic [15:0] d);
        logic [7:0] w0, w1;
        if (v[0] && mq0.size() < 18) mq0.push_back(d[7:0]);
        if (v[1] && mq1.size() < 18) mq1.push_back(d[15:8]);
        while (mq0.size() > 0 && mq1.size() > 0) begin
            w0 = mq0.pop_front();
            w1 = mq1.pop_front();
            if (w1 > w0) exp_a.push_back('{data: w1, ch: 2'd1});
            else         exp_a.push_back('{data: w0, ch: 2'd0});
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [15:0] d, input bit track);
        in_valid_a = v;
        in_data_a  = d;
        if (track) modelA(v, d);
        tick();
        in_valid_a = '0;
    endtask

    task automatic applyStimulusQuad(input logic [3:0] v, input logic [31:0] d,
                                     input logic [7:0] mx_d, input logic [1:0] mx_c,
                                     input logic [7:0] mn_d, input logic [1:0] mn_c,
                                     input bit track);
        in_valid_b = v;
        in_data_b  = d;
        if (track) begin
            exp_bx.push_back('{data: mx_d, ch: mx_c});
            exp_bn.push_back('{data: mn_d, ch: mn_c});
        end
        tick();
        in_valid_b = '0;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while ((exp_a.size() + exp_bx.size() + exp_bn.size()) != 0 && n < limit) begin
            tick();
            n++;
        end
        if ((exp_a.size() + exp_bx.size() + exp_bn.size()) != 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL drain_timeout got %0d pending required 0",
                     exp_a.size() + exp_bx.size() + exp_bn.size());
            exp_a.delete();
            exp_bx.delete();
            exp_bn.delete();
        end
        tick();
    endtask

    // Leaves instance A holding one result with levels {5,3}.
    task automatic build53();
        out_ready_a = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(2'b11, {8'(8'h40 + i), 8'(8'h60 + i)}, 1'b0);
        applyStimulus(2'b01, 16'h0077, 1'b0);
        applyStimulus(2'b01, 16'h0078, 1'b0);
        checkOutput("a_setup_level0", level_a[4:0], 5);
        checkOutput("a_setup_level1", level_a[9:5], 3);
        checkOutput("a_setup_valid", out_valid_a, 1);
    endtask

    initial begin
        rst = 1'b1;
        flush_a = 0; clear_drop_a = 0; out_ready_a = 0; in_valid_a = '0; in_data_a = '0;
        flush_b = 0; clear_drop_b = 0; out_ready_b = 0; in_valid_b = '0; in_data_b = '0;
        repeat (2) tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_out_valid", out_valid_a, 0);
        checkOutput("rst_out_data", out_data_a, 0);
        checkOutput("rst_out_ch", out_ch_a, 0);
        checkOutput("rst_level_a", level_a, 0);
        checkOutput("rst_in_ready_a", in_ready_a, 2'b11);
        checkOutput("rst_drop_a", drop_flag_a, 0);
        checkOutput("rst_in_ready_b", in_ready_b, 4'hF);
        checkOutput("rst_out_valid_c", out_valid_c, 0);

        $display("[TB] basic max");
        out_ready_a = 1'b1;
        applyStimulus(2'b11, 16'h3412, 1'b1);
        tick();
        checkOutput("basic_out_valid", out_valid_a, 1);
        checkOutput("basic_level", level_a, 0);
        tick();
        checkOutput("basic_valid_drop", out_valid_a, 0);

        $display("[TB] backpressure");
        out_ready_a = 1'b0;
        applyStimulus(2'b11, 16'h2010, 1'b1);
        applyStimulus(2'b11, 16'h0545, 1'b1);
        applyStimulus(2'b11, 16'h3333, 1'b1);
        tick();
        checkOutput("bp_level0", level_a[4:0], 2);
        checkOutput("bp_level1", level_a[9:5], 2);
        checkOutput("bp_hold_data", out_data_a, 8'h20);
        checkOutput("bp_hold_ch", out_ch_a, 1);
        tick();
        checkOutput("bp_hold_valid2", out_valid_a, 1);
        checkOutput("bp_hold_data2", out_data_a, 8'h20);
        out_ready_a = 1'b1;
        tick();
        checkOutput("bp_stream_data", out_data_a, 8'h45);
        checkOutput("bp_stream_level", level_a, {5'd1, 5'd1});
        waitDrain(20);

        $display("[TB] full, overflow and wrap");
        for (int i = 0; i < 18; i++) applyStimulus(2'b01, {8'h00, 8'(i * 13 + 5)}, 1'b1);
        checkOutput("full_in_ready", in_ready_a, 2'b10);
        checkOutput("full_level0", level_a[4:0], 18);
        applyStimulus(2'b01, 16'h00EE, 1'b1);
        checkOutput("ovf_drop", drop_flag_a, 2'b01);
        checkOutput("ovf_level0", level_a[4:0], 18);
        for (int i = 0; i < 18; i++) applyStimulus(2'b10, {8'(250 - i * 11), 8'h00}, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(2'b11, {8'(200 - i * 17), 8'(i * 21)}, 1'b1);
        waitDrain(60);
        checkOutput("wrap_level", level_a, 0);
        checkOutput("wrap_drop_sticky", drop_flag_a, 2'b01);

        $display("[TB] flush mid-operation");
        build53();
        flush_a = 1'b1;
        in_valid_a = 2'b11;
        in_data_a = 16'hABCD;
        tick();
        flush_a = 1'b0;
        in_valid_a = '0;
        checkOutput("flush_level", level_a, 0);
        checkOutput("flush_out_valid", out_valid_a, 0);
        checkOutput("flush_drop_kept", drop_flag_a, 2'b01);
        tick();
        checkOutput("flush_quiet", out_valid_a, 0);

        $display("[TB] reset mid-operation");
        build53();
        rst = 1'b1;
        in_valid_a = 2'b11;
        tick();
        rst = 1'b0;
        in_valid_a = '0;
        checkOutput("rst2_level", level_a, 0);
        checkOutput("rst2_out_valid", out_valid_a, 0);
        checkOutput("rst2_drop", drop_flag_a, 0);
        checkOutput("rst2_in_ready", in_ready_a, 2'b11);

        $display("[TB] four-channel max/min with ties");
        out_ready_b = 1'b1;
        applyStimulusQuad(4'hF, 32'h90070750, 8'h90, 2'd3, 8'h07, 2'd1, 1'b1);
        applyStimulusQuad(4'hF, 32'hFF00FF00, 8'hFF, 2'd1, 8'h00, 2'd0, 1'b1);
        applyStimulusQuad(4'hF, 32'h80808080, 8'h80, 2'd0, 8'h80, 2'd0, 1'b1);
        applyStimulusQuad(4'hF, 32'hC47FC301, 8'hC4, 2'd3, 8'h01, 2'd0, 1'b1);
        applyStimulusQuad(4'hF, 32'hA13B3CA0, 8'hA1, 2'd3, 8'h3B, 2'd2, 1'b1);
        waitDrain(20);

        $display("[TB] drop flag set and clear");
        for (int i = 0; i < 4; i++) applyStimulusQuad(4'b0100, 32'h00110000, 0, 0, 0, 0, 1'b0);
        checkOutput("b_full_in_ready", in_ready_b, 4'b1011);
        checkOutput("b_full_level2", level_b[8:6], 4);
        applyStimulusQuad(4'b0100, 32'h00220000, 0, 0, 0, 0, 1'b0);
        checkOutput("b_ovf_drop", drop_flag_b, 4'b0100);
        clear_drop_b = 1'b1;
        applyStimulusQuad(4'b0100, 32'h00330000, 0, 0, 0, 0, 1'b0);
        checkOutput("b_set_wins", drop_flag_b, 4'b0100);
        tick();
        clear_drop_b = 1'b0;
        checkOutput("b_cleared", drop_flag_b, 4'b0000);
        checkOutput("c_cleared", drop_flag_c, 4'b0000);
        flush_b = 1'b1;
        tick();
        flush_b = 1'b0;
        checkOutput("b_flush_level", level_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multi_chan_compare_fifo.md
Name: multi_chan_compare_fifo

Overview:
- Parametrised N-channel successor to the two-FIFO packet comparator.
- Each channel owns a synchronous FIFO of configurable width and depth.
- When every channel holds data and the output stage can accept, one word is popped from every channel in the same cycle. The words are compared by magnitude, and the winning word and its channel index go to a registered valid/ready output.
- Runtime-free selection of maximum or minimum via parameter; sticky per-channel overflow flags and fill levels support monitoring.

Parameters:
- NUM_CH, 2, number of input channels (>=2).
- DATA_W, 8, word width per channel.
- DEPTH, 18, entries per channel FIFO (>=2; need not be a power of two).
- MODE, 0, 0 = pick greatest word, 1 = pick smallest word.
- CH_W, $clog2(NUM_CH), width of channel index.
- CNT_W, $clog2(DEPTH+1), width of fill-level count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all FIFOs and output register.
- in_valid  in  NUM_CH  per-channel write request.
- in_data  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel not-full.
- level  out  NUM_CH*CNT_W  per-channel occupancy, channel c at [c*CNT_W +: CNT_W].
- drop_flag  out  NUM_CH  sticky: write attempted while full.
- clear_drop  in  1  clears all drop_flag bits.
- out_valid  out  1  result valid.
- out_data  out  DATA_W  winning word.
- out_ch  out  CH_W  index of winning channel.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset, sampled on the clk rising edge while rst=1:
  - All pointers and levels go to 0.
  - in_ready goes to all-1.
  - drop_flag, out_valid, out_data and out_ch go to 0.
  - rst overrides flush and all other inputs.
- Channel FIFO:
  - Write fires when in_valid[c] && in_ready[c].
  - in_ready[c] = (level[c] != DEPTH), derived from registered level only. A full channel refuses writes even if a pop occurs in the same cycle.
  - Write pointer and read pointer each wrap from DEPTH-1 to 0.
  - level[c] behaviour per cycle:
    - +1 on write only.
    - -1 on pop only.
    - Unchanged on simultaneous write and pop.
  - A word written at edge t is poppable from cycle t+1 (first-word latency 1).
- Overflow: in_valid[c] && !in_ready[c] sets drop_flag[c] at the next edge and discards the data.
  - clear_drop clears all bits.
  - When clear_drop and a new overflow coincide, the set wins.
- Fire condition: all_nonempty && (!out_valid || out_ready) && !flush.
  - On fire, every channel pops its head word in the same cycle.
  - The result is loaded into the output register and out_valid=1 from the next cycle.
- Compare:
  - Unsigned magnitude comparison over the NUM_CH head words.
  - MODE=0 selects the maximum; MODE=1 selects the minimum.
  - Ties go to the lowest channel index.
  - Losing words are discarded.
- Output handshake:
  - out_valid, out_data and out_ch are held stable while out_valid && !out_ready.
  - Transfer occurs when out_valid && out_ready.
  - A new fire in that same cycle reloads the register, giving 1 result per cycle sustained throughput.
  - With no fire, out_valid drops.
- Flush:
  - All levels and pointers go to 0 and out_valid goes to 0 at the next edge.
  - Writes and pops presented in the flush cycle are ignored.
  - drop_flag is unaffected.
- No pop occurs unless all channels are non-empty. A stalled channel blocks all channels, which is the intended lock-step behaviour.

Decomposition:
- Shared package (proc_pkg) holds:
  - MODE_MAX=0 and MODE_MIN=1 constants.
  - Default DATA_W and DEPTH values.
- Sub-module proc_chan_fifo (DATA_W, DEPTH):
  - One synchronous FIFO with push/pop, level, full and empty.
  - Honours rst and flush.
  - Instantiated NUM_CH times by a generate loop.
- Comparator tree and output register live in the top module.

Test Plan:
- Basic max, NUM_CH=2, MODE=0: write ch0=0x12, ch1=0x34, out_ready=1 -> two edges after the write, out_valid=1, out_data=0x34, out_ch=1, then both levels return to 0.
- Tie and min mode, NUM_CH=4, MODE=1:
  - Write {0x50,0x07,0x07,0x90} -> out_data=0x07, out_ch=1.
  - Write {0x00,0xFF,0x00,0xFF} with MODE=0 -> out_data=0xFF, out_ch=1.
- Backpressure:
  - Load 3 words per channel, hold out_ready=0 -> one result holds stable and levels settle at 2.
  - Release out_ready -> the remaining 2 results stream on consecutive cycles in FIFO order.
- Full, overflow and wrap, DEPTH=18:
  - Fill ch0 with 18 words while ch1 stays empty -> in_ready[0]=0 and level[0]=18.
  - A 19th write sets drop_flag[0] and leaves level[0]=18.
  - Then feed ch1 and drain 30 total words through pointer wrap -> outputs match a reference model; clear_drop returns drop_flag to 0.
- Flush and reset mid-operation:
  - With out_valid=1 and levels {5,3}, pulse flush together with in_valid -> next cycle levels {0,0}, out_valid=0, drop_flag unchanged.
  - Repeat with rst -> drop_flag also 0 and in_ready all-1.
